bounce_gen: RTL

Synthesizable mechanical-switch emulator. It turns a clean level request into a bouncy pin waveform. It drives the debouncer's btn input during on-board self-test, so debounce timing can be exercised without a physical button. Bounce count and gap lengths are pseudo-random from an internal LFSR, and are deterministic for a given seed.

---
 rtl/bounce_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bounce_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// bounce_gen : turns a clean level request into a bouncy, LFSR-timed pin.
// Rev 1.0
// ============================================================================
module bounce_gen #(
  parameter int          PAIR_W        = 2,
  parameter int          GAP_W         = 4,
  parameter int          SETTLE_CYCLES = 32,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic        IDLE_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic target,
  input  logic enable,
  output logic btn,
  output logic busy,
  output logic done
);

  localparam int          c_SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [1:0]  S_IDLE     = 2'd0;
  localparam logic [1:0]  S_BOUNCE   = 2'd1;
  localparam logic [1:0]  S_SETTLE   = 2'd2;
  localparam logic [15:0] c_SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] c_MASK     = 16'hB400;

  localparam logic [c_SETTLE_W-1:0] c_SETTLE_LOAD = c_SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [c_SETTLE_W-1:0] c_SETTLE_ONE  = c_SETTLE_W'(1);
  localparam logic [GAP_W:0]        c_GAP_ONE     = (GAP_W + 1)'(1);
  localparam logic [PAIR_W:0]       c_EDGE_ONE    = (PAIR_W + 1)'(1);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [15:0]           r_lfsr;
  logic [15:0]           w_lfsr_nxt;
  logic [PAIR_W:0]       r_edges_left;
  logic [PAIR_W:0]       w_edges_nxt;
  logic [GAP_W:0]        r_gap_cnt;
  logic [GAP_W:0]        w_gap_nxt;
  logic [c_SETTLE_W-1:0] r_settle_cnt;
  logic [c_SETTLE_W-1:0] w_settle_nxt;
  logic                  r_btn;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_btn_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;

  logic [PAIR_W-1:0]     w_pairs;
  logic [GAP_W:0]        w_gap;
  logic                  w_start;
  logic                  w_toggle;
  logic                  w_settled;

  // Galois right shift; free-running in every state so timing depends only on the cycle count since reset.
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_MASK : 16'h0000);

  assign w_pairs   = r_lfsr[PAIR_W-1:0];
  assign w_gap     = {1'b0, r_lfsr[GAP_W+7:8]} + c_GAP_ONE;
  assign w_start   = (r_state == S_IDLE) && (target != r_btn);
  assign w_toggle  = (r_state == S_BOUNCE) && (r_gap_cnt == c_GAP_ONE);
  assign w_settled = (r_state == S_SETTLE) && (r_settle_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_lfsr       <= c_SEED;
      r_edges_left <= '0;
      r_gap_cnt    <= '0;
      r_settle_cnt <= '0;
      r_btn        <= IDLE_LEVEL;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_edges_left <= w_edges_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_btn        <= w_btn_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_edges_nxt  = r_edges_left;
    w_gap_nxt    = r_gap_cnt;
    w_settle_nxt = r_settle_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start && enable) begin
          w_edges_nxt = {w_pairs, 1'b0};
          w_gap_nxt   = w_gap;
          if (w_pairs == '0) begin
            w_state_nxt  = S_SETTLE;
            w_settle_nxt = c_SETTLE_LOAD;
          end else begin
            w_state_nxt = S_BOUNCE;
          end
        end
      end
      S_BOUNCE: begin
        if (w_toggle) begin
          w_edges_nxt = r_edges_left - c_EDGE_ONE;
          w_gap_nxt   = w_gap;
          if (r_edges_left == c_EDGE_ONE) begin
            w_state_nxt  = S_SETTLE;
            w_settle_nxt = c_SETTLE_LOAD;
          end
        end else begin
          w_gap_nxt = r_gap_cnt - c_GAP_ONE;
        end
      end
      S_SETTLE: begin
        if (w_settled) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_settle_nxt = r_settle_cnt - c_SETTLE_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The bypass path also lands here: with enable low, btn follows target without raising busy.
  always_comb begin
    w_btn_nxt  = r_btn;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_btn_nxt  = target;
          w_busy_nxt = enable;
        end
      end
      S_BOUNCE: begin
        if (w_toggle) begin
          w_btn_nxt = ~r_btn;
        end
      end
      S_SETTLE: begin
        if (w_settled) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign btn  = r_btn;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire
